// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, instruction width, NOP.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam int              ILEN        = 32;
    localparam int              INSTR_BYTES = 4;
    localparam logic [ILEN-1:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Phase-driven instruction fetch: one memory request per fetch phase, result held
// until commit, then PC advances sequentially or to the redirect target.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            phase_fetch,
    input  logic            phase_execute,
    input  logic            phase_commit,
    output logic            stall,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] instr,
    output logic            instr_valid,
    output logic            fetch_fault
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instr;
    logic            r_valid;
    logic            r_fault;

    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_pc_redir;

    // Sequential PC wraps naturally at 2^XLEN; redirect targets are forced word-aligned.
    assign w_pc_seq   = r_pc + XLEN'(INSTR_BYTES);
    assign w_pc_redir = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (phase_fetch)   r_state <= S_REQ;
                S_REQ:  if (mem_req_ready) r_state <= S_WAIT;
                S_WAIT: if (mem_rsp_valid) begin
                    r_instr <= mem_rsp_data;
                    r_fault <= mem_rsp_err;
                    r_valid <= 1'b1;
                    r_state <= S_HOLD;
                end
                // A faulting fetch still commits; the consumer decides what to do with it.
                S_HOLD: if (phase_commit) begin
                    r_pc    <= redirect_valid ? w_pc_redir : w_pc_seq;
                    r_valid <= 1'b0;
                    r_fault <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall = !rst && ((r_state == S_IDLE && phase_fetch) ||
                            r_state == S_REQ || r_state == S_WAIT);

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_addr  = r_pc;
    assign pc            = r_pc;
    assign instr         = r_instr;
    assign instr_valid   = r_valid;
    assign fetch_fault   = r_fault;

    a_onehot_phase: assert property (@(posedge clk) disable iff (rst)
        $onehot0({phase_fetch, phase_execute, phase_commit}));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (phase_execute && r_state == S_HOLD) |=> ($stable(r_instr) && $stable(r_pc) && $stable(r_fault)));

endmodule
